divider_arbiter: RTL and testbench

- Shares one sequential 64/64->32 binary divider core among NUM_REQ requesters.
- Arbitration is round-robin, with one operation in flight at a time.
- Per-requester valid/ready request ports feed a single tagged response port. The arbiter launches the core with a one-cycle div_en pulse and collects the result on the core's done pulse.
- Divide-by-zero is answered locally without using the core. A watchdog bounds the wait for done.

---
 rtl/divider_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_divider_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one sequential 64/64->32 divider core among
// NUM_REQ valid/ready requesters, with local divide-by-zero handling and a
// watchdog on the core's done pulse.
module divider_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 48
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*64-1:0]  req_dividend,
  input  logic [NUM_REQ*64-1:0]  req_divisor,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [31:0]            resp_quotient,
  output logic                   resp_err,
  output logic                   div_en,
  output logic [63:0]            div_dividend,
  output logic [63:0]            div_divisor,
  input  logic [31:0]            div_quotient,
  input  logic                   div_done
);

  localparam int unsigned DW = 64;
  localparam int unsigned QW = 32;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  win_id_q, win_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            resp_valid_d;
  logic [IDW-1:0]  resp_id_d;
  logic [QW-1:0]   resp_quotient_d;
  logic            resp_err_d;
  logic            div_en_d;
  logic [DW-1:0]   div_dividend_d;
  logic [DW-1:0]   div_divisor_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  logic [DW-1:0]   sel_dividend;
  logic [DW-1:0]   sel_divisor;
  logic            timeout_hit;

  // Round-robin search starting just above the last served requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    sel_dividend = req_dividend[DW*grant_idx +: DW];
    sel_divisor  = req_divisor[DW*grant_idx +: DW];
  end

  // Accept strobe is combinational so the winner sees it in the grant cycle
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      win_id_q      <= '0;
      cnt_q         <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_quotient <= '0;
      resp_err      <= 1'b0;
      div_en        <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      win_id_q      <= win_id_d;
      cnt_q         <= cnt_d;
      resp_valid    <= resp_valid_d;
      resp_id       <= resp_id_d;
      resp_quotient <= resp_quotient_d;
      resp_err      <= resp_err_d;
      div_en        <= div_en_d;
      div_dividend  <= div_dividend_d;
      div_divisor   <= div_divisor_d;
    end
  end

  // Next-state logic; done takes priority over the watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d = (sel_divisor == '0) ? S_RESP : S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (div_done || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping
  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    win_id_d        = win_id_q;
    cnt_d           = cnt_q;
    resp_valid_d    = resp_valid;
    resp_id_d       = resp_id;
    resp_quotient_d = resp_quotient;
    resp_err_d      = resp_err;
    div_en_d        = 1'b0;
    div_dividend_d  = div_dividend;
    div_divisor_d   = div_divisor;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          win_id_d = grant_idx;
          if (sel_divisor == '0) begin
            resp_valid_d    = 1'b1;
            resp_id_d       = grant_idx;
            resp_quotient_d = '1;
            resp_err_d      = 1'b1;
          end else begin
            div_en_d       = 1'b1;
            div_dividend_d = sel_dividend;
            div_divisor_d  = sel_divisor;
          end
        end
      end
      S_LAUNCH: cnt_d = '0;
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (div_done) begin
          resp_valid_d    = 1'b1;
          resp_id_d       = win_id_q;
          resp_quotient_d = div_quotient;
          resp_err_d      = 1'b0;
        end else if (timeout_hit) begin
          resp_valid_d    = 1'b1;
          resp_id_d       = win_id_q;
          resp_quotient_d = '0;
          resp_err_d      = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = win_id_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed self-checking bench for divider_arbiter; the divider core is
// emulated by driving div_done/div_quotient at chosen cycles.
module tb_divider_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TIMEOUT = 48;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_dividend;
  logic [NUM_REQ*64-1:0] req_divisor;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [31:0]           resp_quotient;
  logic                  resp_err;
  logic                  div_en;
  logic [63:0]           div_dividend;
  logic [63:0]           div_divisor;
  logic [31:0]           div_quotient;
  logic                  div_done;

  int errors   = 0;
  int checks   = 0;
  int en_count = 0;

  divider_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_err(resp_err),
    .div_en(div_en), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_done(div_done)
  );

  always #5 clk = ~clk;

  // Count core start pulses mid-cycle
  always @(negedge clk) if (div_en) en_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [63:0] dvd, input logic [63:0] dvs);
    req_dividend[64*id +: 64] = dvd;
    req_divisor[64*id +: 64]  = dvs;
    req_valid[id]             = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, ".resp_id"}, 64'(resp_id), 64'd0);
    chk({tag, ".resp_quotient"}, 64'(resp_quotient), 64'd0);
    chk({tag, ".resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, ".div_en"}, 64'(div_en), 64'd0);
    chk({tag, ".div_dividend"}, div_dividend, 64'd0);
    chk({tag, ".div_divisor"}, div_divisor, 64'd0);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
  endtask

  // One full core operation for requester id, entered in IDLE with its request up
  task automatic do_op(input int id, input logic [31:0] q, input int lat,
                       input int stall, input bit drop);
    logic [63:0] dvd;
    logic [63:0] dvs;
    logic [NUM_REQ-1:0] oh;
    int en0;
    dvd = req_dividend[64*id +: 64];
    dvs = req_divisor[64*id +: 64];
    oh  = NUM_REQ'(1) << id;
    en0 = en_count;
    resp_ready = (stall == 0);
    #1;
    chk("grant", 64'(req_ready), 64'(oh));
    tick();
    if (drop) req_valid[id] = 1'b0;
    chk("launch.div_en", 64'(div_en), 64'd1);
    chk("launch.dividend", div_dividend, dvd);
    chk("launch.divisor", div_divisor, dvs);
    chk("launch.req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("wait.div_en", 64'(div_en), 64'd0);
    repeat (lat) tick();
    chk("wait.no_resp", 64'(resp_valid), 64'd0);
    div_done     = 1'b1;
    div_quotient = q;
    tick();
    div_done = 1'b0;
    chk("resp.valid", 64'(resp_valid), 64'd1);
    chk("resp.id", 64'(resp_id), 64'(id));
    chk("resp.quotient", 64'(resp_quotient), 64'(q));
    chk("resp.err", 64'(resp_err), 64'd0);
    if (stall > 0) begin
      repeat (stall) begin
        tick();
        chk("stall.valid", 64'(resp_valid), 64'd1);
        chk("stall.id", 64'(resp_id), 64'(id));
        chk("stall.quotient", 64'(resp_quotient), 64'(q));
        chk("stall.req_ready", 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
    end
    tick();
    chk("handshake.valid_drop", 64'(resp_valid), 64'd0);
    chk("op.div_en_count", 64'(en_count - en0), 64'd1);
  endtask

  initial begin
    int en0;
    reset        = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    resp_ready   = 1'b1;
    div_quotient = '0;
    div_done     = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // Single request: 100 / 7 = 14, core done 34 cycles after start
    set_req(0, 64'd100, 64'd7);
    do_op(0, 32'd14, 33, 0, 1'b1);

    // All requesters valid from reset: order 1,2,3,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 64'd103, 64'd2);
    set_req(1, 64'd203, 64'd3);
    set_req(2, 64'd303, 64'd4);
    set_req(3, 64'd403, 64'd5);
    en0 = en_count;
    do_op(1, 32'd67, 4, 0, 1'b0);
    do_op(2, 32'd75, 2, 0, 1'b0);
    do_op(3, 32'd80, 6, 0, 1'b0);
    do_op(0, 32'd51, 1, 0, 1'b0);
    do_op(1, 32'd67, 3, 0, 1'b0);
    req_valid = '0;
    chk("rr.div_en_total", 64'(en_count - en0), 64'd5);

    // Divide by zero on requester 2 answered locally
    en0 = en_count;
    set_req(2, 64'd55, 64'd0);
    #1;
    chk("dz.grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    chk("dz.valid", 64'(resp_valid), 64'd1);
    chk("dz.id", 64'(resp_id), 64'd2);
    chk("dz.quotient", 64'(resp_quotient), 64'hFFFF_FFFF);
    chk("dz.err", 64'(resp_err), 64'd1);
    tick();
    chk("dz.valid_drop", 64'(resp_valid), 64'd0);
    chk("dz.no_div_en", 64'(en_count - en0), 64'd0);

    // Watchdog: core never finishes, late done is ignored
    set_req(3, 64'd9, 64'd3);
    #1;
    chk("to.grant", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    chk("to.div_en", 64'(div_en), 64'd1);
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("to.still_waiting", 64'(resp_valid), 64'd0);
    tick();
    chk("to.valid", 64'(resp_valid), 64'd1);
    chk("to.id", 64'(resp_id), 64'd3);
    chk("to.quotient", 64'(resp_quotient), 64'd0);
    chk("to.err", 64'(resp_err), 64'd1);
    tick();
    chk("to.valid_drop", 64'(resp_valid), 64'd0);
    en0 = en_count;
    repeat (4) tick();
    div_done     = 1'b1;
    div_quotient = 32'hDEAD;
    tick();
    div_done = 1'b0;
    chk("late_done.no_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("late_done.no_resp2", 64'(resp_valid), 64'd0);
    chk("late_done.no_div_en", 64'(en_count - en0), 64'd0);
    set_req(0, 64'd20, 64'd4);
    do_op(0, 32'd5, 3, 0, 1'b1);

    // Response back-pressure for 10 cycles with another requester pending
    set_req(1, 64'd81, 64'd9);
    set_req(2, 64'd64, 64'd8);
    en0 = en_count;
    do_op(1, 32'd9, 5, 10, 1'b1);
    chk("stall.div_en_total", 64'(en_count - en0), 64'd1);
    do_op(2, 32'd8, 2, 0, 1'b1);

    // Reset during WAIT abandons the operation
    set_req(3, 64'd77, 64'd7);
    #1;
    chk("rst.grant", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    tick();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk_all_zero("rst_wait");
    reset = 1'b0;
    tick();
    chk("rst.no_resp", 64'(resp_valid), 64'd0);
    set_req(0, 64'd50, 64'd5);
    set_req(1, 64'd90, 64'd6);
    do_op(1, 32'd15, 7, 0, 1'b1);
    do_op(0, 32'd10, 2, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
